// File: rtl/dcache_overhead_array.sv
// dcache_overhead_array: N-way tag/valid/dirty store, one RAM bank per way, self-clearing after reset.
// Latency: rd_data/rd_valid one cycle after rd_en; same-set write/read collision is write-first per way.
// Backpressure: none; requests are ignored while init_busy=1, so the controller holds them until it drops.
// Ports: clk, rst (synchronous, active-high); wr_en/wr_addr/wr_way_mask/wr_data write port;
//        rd_en/rd_addr -> rd_data/rd_valid read port (way w at bits [w*DATA_WIDTH +: DATA_WIDTH]);
//        init_busy high while the array is being cleared after reset.
// Optional: define DCACHE_OVERHEAD_PARITY_EN to store an even-parity bit per word and add rd_parity_err.
module dcache_overhead_array #(
    parameter int WAYS       = 2,
    parameter int LINES      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [WAYS-1:0]            wr_way_mask,
    input  logic [WAYS*DATA_WIDTH-1:0] wr_data,
    input  logic                       rd_en,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic [WAYS*DATA_WIDTH-1:0] rd_data,
    output logic                       rd_valid,
    output logic                       init_busy
`ifdef DCACHE_OVERHEAD_PARITY_EN
    ,
    output logic [WAYS-1:0]            rd_parity_err
`endif
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

`ifdef DCACHE_OVERHEAD_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  clearing;
    logic                  ready;
    logic                  rd_acc;

    // rst wins over everything in the same cycle, so neither clear writes
    // nor user requests touch the RAM while it is asserted.
    assign clearing  = !rst && (state == ST_CLEAR);
    assign ready     = !rst && (state == ST_READY);
    assign rd_acc    = ready && rd_en;
    assign init_busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (state == ST_CLEAR) begin
                ptr <= ptr + 1'b1;
                if (ptr == ADDR_WIDTH'(LINES - 1)) begin
                    state <= ST_READY;
                end
            end
        end
    end

    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_way
            logic [WORD_W-1:0]     mem [0:LINES-1];
            logic [WORD_W-1:0]     word_q;
            logic [WORD_W-1:0]     wword;
            logic [DATA_WIDTH-1:0] wdat;
            logic [ADDR_WIDTH-1:0] waddr;
            logic                  we;
            logic                  byp;

            assign wdat = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
`ifdef DCACHE_OVERHEAD_PARITY_EN
            assign wword = clearing ? '0 : {^wdat, wdat};
`else
            assign wword = clearing ? '0 : wdat;
`endif
            // The clear sequencer borrows the write port; user writes only in READY.
            assign we    = clearing || (ready && wr_en && wr_way_mask[w]);
            assign waddr = clearing ? ptr : wr_addr;
            // Write-first: a same-set write to this way is forwarded to the read register.
            assign byp   = wr_en && wr_way_mask[w] && (wr_addr == rd_addr);

            // Array itself carries no reset so it maps onto block RAM.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wword;
                end
            end

            // Only updated on an accepted read, so rd_data holds between reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_q <= '0;
                end else if (rd_acc) begin
                    if (byp) begin
                        word_q <= wword;
                    end else begin
                        word_q <= mem[rd_addr];
                    end
                end
            end

            assign rd_data[w*DATA_WIDTH +: DATA_WIDTH] = word_q[DATA_WIDTH-1:0];
`ifdef DCACHE_OVERHEAD_PARITY_EN
            // Stored bit is even parity of the data, so a good word XORs to 0.
            // Bypassed words carry freshly computed parity and never flag.
            assign rd_parity_err[w] = rd_valid && (^word_q);
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dcache_overhead_array.sv
module tb_dcache_overhead_array;
    localparam int WAYS  = 2;
    localparam int LINES = 64;
    localparam int AW    = 6;
    localparam int DW    = 24;
    localparam int BW    = WAYS * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [WAYS-1:0] wr_way_mask = '0;
    logic [BW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [BW-1:0] rd_data;
    logic          rd_valid;
    logic          init_busy;
`ifdef DCACHE_OVERHEAD_PARITY_EN
    logic [WAYS-1:0] rd_parity_err;
    logic [WAYS-1:0] flip [LINES];
`endif

    always #5 clk = ~clk;

    dcache_overhead_array #(
        .WAYS(WAYS), .LINES(LINES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_way_mask(wr_way_mask), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .init_busy(init_busy)
`ifdef DCACHE_OVERHEAD_PARITY_EN
        , .rd_parity_err(rd_parity_err)
`endif
    );

    typedef struct {
        logic [BW-1:0]   data;
        logic [WAYS-1:0] perr;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [WAYS][LINES];
    int            n_cmp = 0;
    int            n_err = 0;
    int            clear_left = 0;
    logic          mon_on = 1'b0;
    logic [BW-1:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a read.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (rd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_rd_valid", 64'(rd_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(e.data));
                    last_data = e.data;
`ifdef DCACHE_OVERHEAD_PARITY_EN
                    chk("rd_parity_err", 64'(rd_parity_err), 64'(e.perr));
`endif
                end
            end else begin
                chk("rd_valid_low", 64'(rd_valid), 64'd0);
                chk("rd_data_hold", 64'(rd_data), 64'(last_data));
`ifdef DCACHE_OVERHEAD_PARITY_EN
                chk("perr_idle", 64'(rd_parity_err), 64'd0);
`endif
            end
        end
    end

    task automatic model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int a = 0; a < LINES; a++)
                model[w][a] = '0;
`ifdef DCACHE_OVERHEAD_PARITY_EN
        for (int a = 0; a < LINES; a++) flip[a] = '0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        clear_left = LINES;
        last_data  = '0;
        mon_on     = 1'b1;
    endtask

    // One clock of stimulus; the expected read result is queued before the edge.
    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [WAYS-1:0] m,
                         input logic [BW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        exp_t e;
        chk("init_busy", 64'(init_busy), 64'(clear_left > 0));
        wr_en = we; wr_addr = wa; wr_way_mask = m; wr_data = wd;
        rd_en = re; rd_addr = ra;
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (re) begin
                e.data = '0;
                e.perr = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (we && m[w] && wa == ra) begin
                        e.data[w*DW +: DW] = wd[w*DW +: DW];
                    end else begin
                        e.data[w*DW +: DW] = model[w][ra];
`ifdef DCACHE_OVERHEAD_PARITY_EN
                        e.perr[w] = flip[ra][w];
`endif
                    end
                end
                sb.push_back(e);
            end
            if (we) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (m[w]) begin
                        model[w][wa] = wd[w*DW +: DW];
`ifdef DCACHE_OVERHEAD_PARITY_EN
                        flip[wa][w] = 1'b0;
`endif
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cycle(1'b0, '0, '0, '0, 1'b1, a);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WAYS-1:0] m, input logic [BW-1:0] d);
        cycle(1'b1, a, m, d, 1'b0, '0);
    endtask

    initial begin
        logic [BW-1:0] rdat;

        @(posedge clk); #1;
        do_reset();
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_init_busy", 64'(init_busy), 64'd1);

        // Requests during clear must be ignored and produce no rd_valid.
        for (int i = 0; i < LINES; i++) begin
            rdat = BW'({$urandom(), $urandom()});
            cycle(1'b1, AW'(2), '1, rdat, 1'b1, AW'(2));
        end
        rd(AW'(0)); rd(AW'(31)); rd(AW'(63)); rd(AW'(2));
        idle(2);

        // Masked write leaves way0 at its cleared value.
        wr(AW'(5), 2'b10, {24'hABCDEF, 24'h123456});
        rd(AW'(5));
        idle(1);

        // Same-set collision: written way forwarded, unmasked way from RAM.
        wr(AW'(7), 2'b11, {24'h111111, 24'h222222});
        idle(1);
        cycle(1'b1, AW'(7), 2'b01, {24'h0, 24'h333333}, 1'b1, AW'(7));
        rd(AW'(7)); rd(AW'(7));
        idle(1);

        // Randomised traffic on a narrow address range to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            rdat = BW'({$urandom(), $urandom()});
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), WAYS'($urandom_range(0, 3)),
                  rdat, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        end
        idle(2);

        // Reset in READY, then again 10 cycles into CLEAR.
        wr(AW'(3), '1, {24'hFFFFFF, 24'hFFFFFF});
        rd(AW'(3));
        idle(2);
        do_reset();
        idle(10);
        do_reset();
        idle(LINES);
        rd(AW'(3));
        idle(2);

`ifdef DCACHE_OVERHEAD_PARITY_EN
        wr(AW'(9), '1, {24'hAAAAAA, 24'h555555});
        idle(1);
        dut.g_way[0].mem[9][0] = ~dut.g_way[0].mem[9][0];
        model[0][9][0] = ~model[0][9][0];
        flip[9][0] = 1'b1;
        rd(AW'(9));
        rd(AW'(10));
        idle(2);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
